// File: rtl/weight_bank_pkg.sv
// Shared types and default sizing for the weight_bank slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package weight_bank_pkg;

    // Burst-loader state; encodings are fixed so debug dumps stay comparable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } wbState_t;

    localparam int WB_DW   = 8;
    localparam int WB_NTAP = 25;

endpackage

// File: rtl/weight_tap_reg.sv
// One tap of the bank: a shadow register written by the loader and an active
// register that copies the shadow on commit.
// Latency: 1 cycle for write to shadow, 1 cycle for commit to active.
// Backpressure: none.
//
// Ports: clk, rst (sync active-high), wr_en/d load the shadow register,
// commit copies shadow->active, shadow/active are the register outputs.
module weight_tap_reg
    import weight_bank_pkg::*;
#(
    parameter int DW = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          commit,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] shadow,
    output logic [DW-1:0] active
);

    // A coincident write and commit both act: active takes the pre-edge
    // shadow value, shadow takes the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) begin
                shadow <= d;
            end
            if (commit) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/weight_bank.sv
// Double-buffered NTAP x DW coefficient bank: random or burst loads into a
// shadow bank, atomic one-cycle commit into the active bank driving oW.
// Latency: 1 cycle write->shadow, 1 cycle commit->oW; no backpressure.
//
// Ports: iCLK, iRST (sync active-high); loader iWren/iAddr/iWeight; iStart
// begins a burst at tap 0; iCommit copies shadow->active. oW is the active
// bank (tap k on [k*DW +: DW]); oBusy = burst running, oFull = burst done,
// oValid = committed at least once, oErr = sticky error (cleared by iStart).
// Optional: define WEIGHT_BANK_READBACK_EN to add iRdAddr/oRdData, a
// registered read of the shadow bank (out-of-range addresses return 0).
module weight_bank
    import weight_bank_pkg::*;
#(
    parameter int DW   = WB_DW,
    parameter int NTAP = WB_NTAP,
    parameter int AW   = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iWren,
    input  logic [AW-1:0]       iAddr,
    input  logic [DW-1:0]       iWeight,
    input  logic                iStart,
    input  logic                iCommit,
`ifdef WEIGHT_BANK_READBACK_EN
    input  logic [AW-1:0]       iRdAddr,
    output logic [DW-1:0]       oRdData,
`endif
    output logic [NTAP*DW-1:0]  oW,
    output logic                oBusy,
    output logic                oFull,
    output logic                oValid,
    output logic                oErr
);

    localparam int             AWX      = AW + 1;
    // One extra bit so NTAP itself is representable for the range check.
    localparam logic [AW:0]    NTAP_EXT = AWX'(NTAP);
    localparam logic [AW-1:0]  LAST     = AW'(NTAP - 1);

    wbState_t      state, stateNext;
    logic [AW-1:0] ptr, ptrNext;
    logic          valid, validNext;
    logic          err, errNext;

    logic          wrDo;
    logic [AW-1:0] wrAddr;
    logic          commitDo;
    logic          addrInRange;

    logic [DW-1:0] shadowArr [NTAP];

    assign addrInRange = ({1'b0, iAddr} < NTAP_EXT);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            ptr   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            valid <= validNext;
            err   <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        validNext = valid;
        errNext   = err;
        wrDo      = 1'b0;
        wrAddr    = iAddr;
        commitDo  = 1'b0;

        if (iStart) begin
            // Start wins over everything else, including a coincident commit.
            stateNext = LOAD;
            ptrNext   = '0;
            errNext   = 1'b0;
            if (iWren) begin
                wrDo   = 1'b1;
                wrAddr = '0;
                if (LAST == '0) begin
                    stateNext = FULL;
                end else begin
                    ptrNext = AW'(1);
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    if (iWren) begin
                        wrDo   = 1'b1;
                        wrAddr = ptr;
                        if (ptr == LAST) begin
                            stateNext = FULL;
                            ptrNext   = '0;
                        end else begin
                            ptrNext = ptr + AW'(1);
                        end
                    end
                    // Committing a half-loaded kernel is refused, burst goes on.
                    if (iCommit) begin
                        errNext = 1'b1;
                    end
                end
                IDLE, FULL: begin
                    if (iWren) begin
                        if (addrInRange) begin
                            wrDo = 1'b1;
                        end else begin
                            errNext = 1'b1;
                        end
                    end
                    if (iCommit) begin
                        commitDo  = 1'b1;
                        validNext = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    ptrNext   = '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NTAP; k++) begin : gTap
        logic tapWr;
        assign tapWr = wrDo && (wrAddr == AW'(k));

        weight_tap_reg #(
            .DW (DW)
        ) uTap (
            .clk    (iCLK),
            .rst    (iRST),
            .wr_en  (tapWr),
            .commit (commitDo),
            .d      (iWeight),
            .shadow (shadowArr[k]),
            .active (oW[k*DW +: DW])
        );
    end

    assign oBusy  = (state == LOAD);
    assign oFull  = (state == FULL);
    assign oValid = valid;
    assign oErr   = err;

`ifdef WEIGHT_BANK_READBACK_EN
    logic [DW-1:0] rdMux;

    // Decoding by equality leaves out-of-range addresses at the 0 default.
    always_comb begin
        rdMux = '0;
        for (int k = 0; k < NTAP; k++) begin
            if (iRdAddr == AW'(k)) begin
                rdMux = shadowArr[k];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRdData <= '0;
        end else begin
            oRdData <= rdMux;
        end
    end
`endif

endmodule
